// File: rtl/operand_fetch.sv
// ============================================================================
// Module      : operand_fetch
// Description : Register-read stage of the in-order pipeline. Drives the
//               regfile read ports, bypasses EX/MEM/WB results, tracks
//               in-flight writes per register, stalls decode on RAW hazards
//               and registers resolved operands into a valid/ready slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic            id_use_rs1_i,
  input  logic            id_use_rs2_i,
  input  logic [4:0]      id_rd_i,
  input  logic            id_rd_we_i,
  output logic [4:0]      rf_ad1_o,
  output logic [4:0]      rf_ad2_o,
  input  logic [XLEN-1:0] rf_rd1_i,
  input  logic [XLEN-1:0] rf_rd2_i,
  input  logic            ex_we_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            ex_dv_i,
  input  logic [XLEN-1:0] ex_data_i,
  input  logic            mem_we_i,
  input  logic [4:0]      mem_rd_i,
  input  logic            mem_dv_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            of_valid_o,
  input  logic            of_ready_i,
  output logic [XLEN-1:0] of_rs1_val_o,
  output logic [XLEN-1:0] of_rs2_val_o,
  output logic [4:0]      of_rd_o,
  output logic            of_rd_we_o
);

  localparam logic [CNT_W-1:0] c_cnt_max  = '1;
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_zero = '0;

  // Output slot
  logic            of_valid_q;
  logic [XLEN-1:0] of_rs1_val_q;
  logic [XLEN-1:0] of_rs2_val_q;
  logic [4:0]      of_rd_q;
  logic            of_rd_we_q;

  // Per-register pending-write counters (entry 0 never counts)
  logic [31:0][CNT_W-1:0] pend_q;
  logic [31:0][CNT_W-1:0] pend_d;

  // Source resolution, index 0 = rs1, index 1 = rs2
  logic [1:0][4:0]      src_rs;
  logic [1:0]           src_use;
  logic [1:0][XLEN-1:0] src_rf;
  logic [1:0][XLEN-1:0] res_val;
  logic [1:0]           res_haz;

  logic        slot_free;
  logic        hazard;
  logic        struct_stall;
  logic        issue;
  logic [31:0] inc_v;
  logic [31:0] dec_v;

  assign rf_ad1_o = id_rs1_i;
  assign rf_ad2_o = id_rs2_i;

  assign src_rs  = {id_rs2_i, id_rs1_i};
  assign src_use = {id_use_rs2_i, id_use_rs1_i};
  assign src_rf  = {rf_rd2_i, rf_rd1_i};

  // Pick the youngest in-flight writer per source; a writer whose data is not
  // ready yet (still in the OF slot, or a load) forces a stall, as does a
  // pending write that has moved past the stages we can see.
  always_comb begin
    res_val = '0;
    res_haz = '0;
    for (int s = 0; s < 2; s++) begin
      if (src_use[s] && (src_rs[s] != 5'd0)) begin
        if (of_valid_q && of_rd_we_q && (of_rd_q == src_rs[s])) begin
          res_haz[s] = 1'b1;
        end else if (ex_we_i && (ex_rd_i == src_rs[s])) begin
          if (ex_dv_i) res_val[s] = ex_data_i;
          else         res_haz[s] = 1'b1;
        end else if (mem_we_i && (mem_rd_i == src_rs[s])) begin
          if (mem_dv_i) res_val[s] = mem_data_i;
          else          res_haz[s] = 1'b1;
        end else if (wb_we_i && (wb_rd_i == src_rs[s])) begin
          res_val[s] = wb_data_i;
        end else if (pend_q[src_rs[s]] != c_cnt_zero) begin
          res_haz[s] = 1'b1;
        end else begin
          res_val[s] = src_rf[s];
        end
      end
    end
  end

  assign hazard       = |res_haz;
  assign struct_stall = id_rd_we_i && (id_rd_i != 5'd0) && (pend_q[id_rd_i] == c_cnt_max);
  assign slot_free    = !of_valid_q || of_ready_i;
  assign id_ready_o   = slot_free && !hazard && !struct_stall && !flush_i;
  assign issue        = id_valid_i && id_ready_o;

  assign inc_v = (issue && id_rd_we_i && (id_rd_i != 5'd0)) ? (32'd1 << id_rd_i) : 32'd0;
  assign dec_v = (wb_we_i && (wb_rd_i != 5'd0)) ? (32'd1 << wb_rd_i) : 32'd0;

  // Scoreboard next state: issue counts up, retire counts down (saturating),
  // simultaneous issue and retire on the same register cancel out.
  always_comb begin
    pend_d = pend_q;
    if (flush_i) begin
      pend_d = '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (inc_v[r] && !dec_v[r]) begin
          pend_d[r] = pend_q[r] + c_cnt_one;
        end else if (dec_v[r] && !inc_v[r] && (pend_q[r] != c_cnt_zero)) begin
          pend_d[r] = pend_q[r] - c_cnt_one;
        end
      end
    end
  end

  // Scoreboard registers
  always_ff @(posedge clk) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // OF slot: load on issue, hold under backpressure, drain when EX takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      of_valid_q   <= 1'b0;
      of_rs1_val_q <= '0;
      of_rs2_val_q <= '0;
      of_rd_q      <= 5'd0;
      of_rd_we_q   <= 1'b0;
    end else if (flush_i) begin
      of_valid_q   <= 1'b0;
    end else if (issue) begin
      of_valid_q   <= 1'b1;
      of_rs1_val_q <= res_val[0];
      of_rs2_val_q <= res_val[1];
      of_rd_q      <= id_rd_i;
      of_rd_we_q   <= id_rd_we_i;
    end else if (of_ready_i) begin
      of_valid_q   <= 1'b0;
    end
  end

  assign of_valid_o   = of_valid_q;
  assign of_rs1_val_o = of_rs1_val_q;
  assign of_rs2_val_o = of_rs2_val_q;
  assign of_rd_o      = of_rd_q;
  assign of_rd_we_o   = of_rd_we_q;

endmodule

`default_nettype wire
